// File: rtl/redmule_z_store_buffer_pkg.sv
// Shared types for the Z store buffer: control/flag bundles, drain FSM states
// and the element-format helper used to size a Z row.
package redmule_z_store_buffer_pkg;

  typedef enum logic [2:0] {
    FP32,
    FP64,
    FP16,
    FP8,
    FP16ALT
  } fp_format_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP8:     return 8;
      default: return 16;
    endcase
  endfunction

  localparam int unsigned ARRAY_WIDTH = 12;
  localparam int unsigned Z_DW        = 288;
  localparam int unsigned Z_MAX_D     = Z_DW / 16;
  localparam int unsigned Z_SLOTS_W   = $clog2(Z_MAX_D) + 1;
  localparam int unsigned Z_ROWS_W    = $clog2(ARRAY_WIDTH) + 1;

  typedef logic [Z_SLOTS_W-1:0] z_slots_t;
  typedef logic [Z_ROWS_W-1:0]  z_rows_t;

  typedef struct packed {
    logic     capture;
    logic     flush;
    z_slots_t slots;
    z_rows_t  rows;
  } z_buffer_ctrl_t;

  typedef struct packed {
    logic capture_ready;
    logic full;
    logic empty;
    logic drop_err;
  } z_buffer_flgs_t;

  typedef enum logic {
    Z_IDLE,
    Z_DRAIN
  } redmule_z_state_e;

endpackage

// File: rtl/redmule_z_store_buffer_if.sv
// Z row stream towards the store streamer: one DW-wide row with byte strobes
// per valid/ready handshake.
interface redmule_z_store_buffer_if #(
  parameter int unsigned DW = 288
);
  logic [DW-1:0]   z_buffer;
  logic [DW/8-1:0] z_strb;
  logic            z_valid;
  logic            z_ready;

  modport master (output z_buffer, output z_strb, output z_valid, input z_ready);
  modport slave  (input z_buffer, input z_strb, input z_valid, output z_ready);
endinterface

// File: rtl/redmule_z_store_buffer_scm.sv
// Two-bank element storage for the Z store buffer. Columns are written W
// elements at a time, rows are read D elements at a time, so the same array
// performs the column-to-row transpose.
module redmule_z_store_buffer_scm
  import redmule_z_store_buffer_pkg::*;
#(
  parameter  int unsigned BITW = 16,
  parameter  int unsigned W    = ARRAY_WIDTH,
  parameter  int unsigned D    = 18,
  localparam int unsigned CW   = $clog2(D),
  localparam int unsigned RW   = $clog2(W)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic                    wbank_i,
  input  logic [CW-1:0]           wcol_i,
  input  logic [W-1:0][BITW-1:0]  wdata_i,
  input  logic                    rbank_i,
  input  logic [RW-1:0]           rrow_i,
  output logic [D-1:0][BITW-1:0]  rdata_o
);

  logic [BITW-1:0] mem_q [2][W][D];

  // Column write: one element per array row lands in the addressed column.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int w = 0; w < W; w++) begin
        mem_q[wbank_i][w][wcol_i] <= wdata_i[w];
      end
    end
  end

  // Row read: all D columns of the addressed row, combinationally.
  always_comb begin
    for (int c = 0; c < D; c++) begin
      rdata_o[c] = mem_q[rbank_i][rrow_i][c];
    end
  end

endmodule

// File: rtl/redmule_z_store_buffer.sv
// Z store buffer: captures result columns from the datapath array into one of
// two banks and streams completed banks row by row to the store streamer.
// One bank fills while the other drains.
module redmule_z_store_buffer
  import redmule_z_store_buffer_pkg::*;
#(
  parameter  int unsigned DW       = 288,
  parameter  fp_format_e  FpFormat = FP16,
  parameter  int unsigned Width    = ARRAY_WIDTH,
  localparam int unsigned BITW     = fp_width(FpFormat),
  localparam int unsigned D        = DW / BITW
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  z_buffer_ctrl_t              ctrl_i,
  output z_buffer_flgs_t              flags_o,
  input  logic [Width-1:0][BITW-1:0]  z_buffer_i,
  redmule_z_store_buffer_if.master    z_out
);

  localparam int unsigned W  = Width;
  localparam int unsigned CW = $clog2(D);
  localparam int unsigned RW = $clog2(W);

  logic [1:0]       full_q;
  logic             wb_q;
  logic             rb_q;
  z_slots_t         col_q;
  z_rows_t          row_q;
  z_slots_t         slots_b_q [2];
  z_rows_t          rows_b_q  [2];
  logic             drop_err_q;
  redmule_z_state_e state_q, state_d;

  logic             capture_ready;
  logic             cap_fire;
  logic             first_cap;
  logic             flush_fire;
  logic             bank_done;
  logic             hs;
  logic             release_bank;
  z_slots_t         cur_slots;
  z_slots_t         col_inc;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;

  logic [D-1:0][BITW-1:0] rd_row;
  logic [DW-1:0]          z_row;
  logic [DW/8-1:0]        z_strb;
  int                     n_bytes;

  // The write bank accepts data only while it is not waiting to be drained.
  assign capture_ready = ~full_q[wb_q];
  assign cap_fire      = ctrl_i.capture & capture_ready;
  assign first_cap     = cap_fire & (col_q == '0);
  // On the first capture the bank's slot count is not latched yet.
  assign cur_slots     = first_cap ? ctrl_i.slots : slots_b_q[wb_q];
  assign col_inc       = col_q + z_slots_t'(1);
  // A flush completes the bank only if it holds at least one column,
  // counting a capture taking place in the same cycle.
  assign flush_fire    = ctrl_i.flush & ((col_q != '0) | cap_fire);
  assign bank_done     = (cap_fire & (col_inc == cur_slots)) | flush_fire;

  assign hs            = (state_q == Z_DRAIN) & z_out.z_ready;
  assign release_bank  = hs & (row_q == (rows_b_q[rb_q] - z_rows_t'(1)));

  assign full_set      = bank_done    ? (2'b01 << wb_q) : 2'b00;
  assign full_clr      = release_bank ? (2'b01 << rb_q) : 2'b00;

  // Write/read pointers, per-bank geometry, bank occupancy and drop flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q      <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      slots_b_q   <= '{default: '0};
      rows_b_q    <= '{default: '0};
      drop_err_q  <= 1'b0;
    end else if (clear_i) begin
      full_q      <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      slots_b_q   <= '{default: '0};
      rows_b_q    <= '{default: '0};
      drop_err_q  <= 1'b0;
    end else begin
      if (cap_fire) begin
        col_q <= col_inc;
      end
      if (first_cap) begin
        slots_b_q[wb_q] <= ctrl_i.slots;
        rows_b_q[wb_q]  <= ctrl_i.rows;
      end
      if (bank_done) begin
        col_q <= '0;
        wb_q  <= ~wb_q;
        // A flushed bank drains only the columns actually written.
        if (flush_fire) begin
          slots_b_q[wb_q] <= cap_fire ? col_inc : col_q;
        end
      end
      if (hs) begin
        row_q <= row_q + z_rows_t'(1);
      end
      if (release_bank) begin
        row_q <= '0;
        rb_q  <= ~rb_q;
      end
      full_q <= (full_q | full_set) & ~full_clr;
      if (ctrl_i.capture & ~capture_ready) begin
        drop_err_q <= 1'b1;
      end
    end
  end

  // Drain FSM: start on the completing edge so valid rises one cycle later,
  // and chain straight into the other bank when it is already complete.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Z_IDLE: begin
        if (full_q[rb_q] | (bank_done & (wb_q == rb_q))) begin
          state_d = Z_DRAIN;
        end
      end
      Z_DRAIN: begin
        if (release_bank) begin
          state_d = (full_q[~rb_q] | (bank_done & (wb_q != rb_q))) ? Z_DRAIN : Z_IDLE;
        end
      end
      default: state_d = Z_IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Z_IDLE;
    end else if (clear_i) begin
      state_q <= Z_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  redmule_z_store_buffer_scm #(
    .BITW (BITW),
    .W    (W),
    .D    (D)
  ) i_scm (
    .clk_i   (clk_i),
    .we_i    (cap_fire),
    .wbank_i (wb_q),
    .wcol_i  (col_q[CW-1:0]),
    .wdata_i (z_buffer_i),
    .rbank_i (rb_q),
    .rrow_i  (row_q[RW-1:0]),
    .rdata_o (rd_row)
  );

  // Output row: unused columns forced to zero, strobes cover the used bytes.
  always_comb begin
    z_row   = '0;
    z_strb  = '0;
    n_bytes = int'(slots_b_q[rb_q]) * int'(BITW) / 8;
    if (state_q == Z_DRAIN) begin
      for (int c = 0; c < D; c++) begin
        if (c < int'(slots_b_q[rb_q])) begin
          z_row[c*BITW +: BITW] = rd_row[c];
        end
      end
      for (int k = 0; k < DW/8; k++) begin
        if (k < n_bytes) begin
          z_strb[k] = 1'b1;
        end
      end
    end
  end

  assign z_out.z_buffer       = z_row;
  assign z_out.z_strb         = z_strb;
  assign z_out.z_valid        = (state_q == Z_DRAIN);

  assign flags_o.capture_ready = capture_ready;
  assign flags_o.full          = &full_q;
  assign flags_o.empty         = (full_q == 2'b00) & (col_q == '0);
  assign flags_o.drop_err      = drop_err_q;

  a_slots_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    first_cap |-> ((ctrl_i.slots != '0) && (int'(ctrl_i.slots) <= int'(D))));
  a_rows_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    first_cap |-> ((ctrl_i.rows != '0) && (int'(ctrl_i.rows) <= int'(W))));

endmodule

// File: tb/tb_redmule_z_store_buffer.sv
// Bench for the Z store buffer: a table of overflow vectors, directed tile
// sequences and a randomized run, all compared against a queue-based model.
module tb_redmule_z_store_buffer;
  import redmule_z_store_buffer_pkg::*;

  localparam int DW   = 288;
  localparam int BITW = 16;
  localparam int D    = DW / BITW;
  localparam int W    = ARRAY_WIDTH;
  localparam int SB   = DW / 8;

  typedef logic [W-1:0][BITW-1:0] col_t;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           clear_i = 1'b0;
  z_buffer_ctrl_t ctrl_i = '0;
  z_buffer_flgs_t flags_o;
  col_t           z_buffer_i = '0;

  redmule_z_store_buffer_if #(.DW(DW)) zif ();

  redmule_z_store_buffer #(
    .DW       (DW),
    .FpFormat (FP16),
    .Width    (W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .ctrl_i     (ctrl_i),
    .flags_o    (flags_o),
    .z_buffer_i (z_buffer_i),
    .z_out      (zif)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: rows waiting to leave, completed tiles still held,
  // and the tile currently being collected.
  logic [DW-1:0]   q_data [$];
  logic [SB-1:0]   q_strb [$];
  bit              q_last [$];
  int              pend;
  int              m_cols;
  int              m_slots;
  int              m_rows;
  bit              m_drop;
  logic [BITW-1:0] m_col [D][W];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q_data.delete();
    q_strb.delete();
    q_last.delete();
    pend = 0;
    m_cols = 0;
    m_slots = 0;
    m_rows = 0;
    m_drop = 0;
  endtask

  task automatic push_tile(input int n, input int r);
    for (int row = 0; row < r; row++) begin
      logic [DW-1:0] dv;
      logic [SB-1:0] sv;
      dv = '0;
      sv = '0;
      for (int c = 0; c < n; c++) dv[c*BITW +: BITW] = m_col[c][row];
      for (int k = 0; k < n * BITW / 8; k++) sv[k] = 1'b1;
      q_data.push_back(dv);
      q_strb.push_back(sv);
      q_last.push_back(row == r - 1);
    end
    pend++;
    m_cols = 0;
  endtask

  task automatic model_step(input bit cap, input bit fl, input int sl, input int rw,
                            input col_t d, input bit rdy);
    bit cap_ok;
    cap_ok = cap && (pend < 2);
    if (rdy && q_data.size() > 0) begin
      if (q_last[0]) pend--;
      void'(q_data.pop_front());
      void'(q_strb.pop_front());
      void'(q_last.pop_front());
    end
    if (cap && !cap_ok) m_drop = 1;
    if (cap_ok) begin
      if (m_cols == 0) begin
        m_slots = sl;
        m_rows  = rw;
      end
      for (int w = 0; w < W; w++) m_col[m_cols][w] = d[w];
      m_cols++;
    end
    if ((cap_ok && m_cols == m_slots) || (fl && m_cols > 0)) push_tile(m_cols, m_rows);
  endtask

  task automatic check_all(input string tag);
    bit ev;
    ev = (q_data.size() > 0);
    chk({tag, "_valid"}, DW'(zif.z_valid), DW'(ev));
    chk({tag, "_cap_rdy"}, DW'(flags_o.capture_ready), DW'(pend < 2));
    chk({tag, "_full"}, DW'(flags_o.full), DW'(pend == 2));
    chk({tag, "_empty"}, DW'(flags_o.empty), DW'(pend == 0 && m_cols == 0));
    chk({tag, "_drop"}, DW'(flags_o.drop_err), DW'(m_drop));
    chk({tag, "_data"}, zif.z_buffer, ev ? q_data[0] : '0);
    chk({tag, "_strb"}, DW'(zif.z_strb), ev ? DW'(q_strb[0]) : '0);
  endtask

  // One clock: drive at the falling edge, let the rising edge act, compare
  // at the next falling edge.
  task automatic cycle(input bit cap, input bit fl, input int sl, input int rw,
                       input col_t d, input bit rdy, input bit do_chk, input string tag);
    ctrl_i.capture = cap;
    ctrl_i.flush   = fl;
    ctrl_i.slots   = z_slots_t'(sl);
    ctrl_i.rows    = z_rows_t'(rw);
    z_buffer_i     = d;
    zif.z_ready    = rdy;
    model_step(cap, fl, sl, rw, d, rdy);
    @(negedge clk);
    if (do_chk) check_all(tag);
  endtask

  task automatic do_clear(input string tag);
    ctrl_i      = '0;
    zif.z_ready = 1'b0;
    clear_i     = 1'b1;
    model_reset();
    @(negedge clk);
    clear_i = 1'b0;
    check_all(tag);
  endtask

  function automatic col_t tile_col(input int c);
    col_t v;
    for (int w = 0; w < W; w++) v[w] = BITW'(c + 16 * w);
    return v;
  endfunction

  typedef struct {
    bit            cap;
    bit            ready;
    logic [15:0]   base;
    bit            e_valid;
    bit            e_cr;
    bit            e_full;
    bit            e_empty;
    bit            e_drop;
    logic [15:0]   e_d0;
    logic [SB-1:0] e_strb;
  } vec_t;

  vec_t          tbl [5];
  col_t          col;
  logic [DW-1:0] prev;
  bit            rdy;

  initial begin
    // Overflow table: 1-column, 1-row tiles; entries give the state after each edge.
    tbl[0] = '{1'b1, 1'b0, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 36'h3};
    tbl[1] = '{1'b1, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 36'h3};
    tbl[2] = '{1'b1, 1'b0, 16'h0300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 36'h3};
    tbl[3] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 36'h3};
    tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 36'h0};

    zif.z_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check_all("reset");

    for (int i = 0; i < 5; i++) begin
      for (int w = 0; w < W; w++) col[w] = tbl[i].base + BITW'(w);
      cycle(tbl[i].cap, 1'b0, 1, 1, col, tbl[i].ready, 1'b0, "tbl");
      chk($sformatf("tbl%0d_valid", i), DW'(zif.z_valid), DW'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_cap_rdy", i), DW'(flags_o.capture_ready), DW'(tbl[i].e_cr));
      chk($sformatf("tbl%0d_full", i), DW'(flags_o.full), DW'(tbl[i].e_full));
      chk($sformatf("tbl%0d_empty", i), DW'(flags_o.empty), DW'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_drop", i), DW'(flags_o.drop_err), DW'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_d0", i), DW'(zif.z_buffer[15:0]), DW'(tbl[i].e_d0));
      chk($sformatf("tbl%0d_strb", i), DW'(zif.z_strb), DW'(tbl[i].e_strb));
    end
    do_clear("clr_after_tbl");

    // Full tile 18x12, element (w,c) = c+16w.
    for (int c = 0; c < D; c++) cycle(1'b1, 1'b0, 18, 12, tile_col(c), 1'b1, 1'b1, "full_cap");
    chk("full_latency", DW'(zif.z_valid), DW'(1));
    for (int r = 0; r < 12; r++) begin
      chk("full_e0", DW'(zif.z_buffer[15:0]), DW'(16 * r));
      chk("full_e17", DW'(zif.z_buffer[17*BITW +: BITW]), DW'(17 + 16 * r));
      chk("full_strb", DW'(zif.z_strb), DW'({SB{1'b1}}));
      cycle(1'b0, 1'b0, 0, 0, '0, 1'b1, 1'b1, "full_drain");
    end
    chk("full_empty_after", DW'(flags_o.empty), DW'(1));

    // Partial tile: 5 columns, 3 rows.
    for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0, 5, 3, tile_col(c), 1'b0, 1'b1, "part_cap");
    for (int r = 0; r < 3; r++) begin
      chk("part_strb", DW'(zif.z_strb), DW'(36'h3FF));
      chk("part_hi_zero", DW'(zif.z_buffer[DW-1:5*BITW]), '0);
      cycle(1'b0, 1'b0, 0, 0, '0, 1'b1, 1'b1, "part_drain");
    end

    // Ping-pong with backpressure: tile A held, tile B captured while A drains.
    for (int c = 0; c < D; c++) cycle(1'b1, 1'b0, 18, 12, tile_col(c), 1'b0, 1'b1, "pp_a");
    for (int c = 0; c < D; c++) begin
      chk("pp_b_cap_rdy", DW'(flags_o.capture_ready), DW'(1));
      chk("pp_b_not_full", DW'(flags_o.full), DW'(0));
      rdy  = c[0];
      prev = zif.z_buffer;
      cycle(1'b1, 1'b0, 18, 12, tile_col(c + 100), rdy, 1'b1, "pp_b");
      if (!rdy) chk("pp_hold_b", zif.z_buffer, prev);
    end
    chk("pp_full_both", DW'(flags_o.full), DW'(1));
    for (int i = 0; i < 100 && q_data.size() > 0; i++) begin
      rdy  = i[0];
      prev = zif.z_buffer;
      cycle(1'b0, 1'b0, 0, 0, '0, rdy, 1'b1, "pp_drain");
      if (!rdy) chk("pp_hold", zif.z_buffer, prev);
    end

    // Flush together with capture 8 of an 18-slot tile.
    for (int c = 0; c < 7; c++) cycle(1'b1, 1'b0, 18, 2, tile_col(c), 1'b0, 1'b1, "fl_cap");
    cycle(1'b1, 1'b1, 18, 2, tile_col(7), 1'b0, 1'b1, "fl_last");
    for (int r = 0; r < 2; r++) begin
      chk("fl_strb", DW'(zif.z_strb), DW'(36'hFFFF));
      chk("fl_col7", DW'(zif.z_buffer[7*BITW +: BITW]), DW'(7 + 16 * r));
      cycle(1'b0, 1'b0, 0, 0, '0, 1'b1, 1'b1, "fl_drain");
    end
    cycle(1'b0, 1'b1, 0, 0, '0, 1'b1, 1'b1, "fl_noop");

    // Clear while the second row of a drain is presented.
    for (int c = 0; c < D; c++) cycle(1'b1, 1'b0, 18, 4, tile_col(c), 1'b1, 1'b1, "clr_cap");
    cycle(1'b0, 1'b0, 0, 0, '0, 1'b1, 1'b1, "clr_row0");
    do_clear("clr_mid");
    chk("clr_valid", DW'(zif.z_valid), DW'(0));
    chk("clr_cap_rdy", DW'(flags_o.capture_ready), DW'(1));
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 3, 2, tile_col(c + 50), 1'b0, 1'b1, "clr_new");
    chk("clr_new_row0", DW'(zif.z_buffer[15:0]), DW'(50));
    for (int r = 0; r < 2; r++) cycle(1'b0, 1'b0, 0, 0, '0, 1'b1, 1'b1, "clr_new_drain");

    // Randomized traffic with legal tile shapes.
    for (int i = 0; i < 600; i++) begin
      for (int w = 0; w < W; w++) col[w] = BITW'($urandom);
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
            $urandom_range(1, D), $urandom_range(1, W), col,
            $urandom_range(0, 1) == 1, 1'b1, "rnd");
    end
    for (int i = 0; i < 200 && (q_data.size() > 0 || m_cols > 0); i++) begin
      cycle(1'b0, (m_cols > 0), 0, 0, '0, 1'b1, 1'b1, "rnd_flush");
    end
    chk("final_empty", DW'(flags_o.empty), DW'(1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
